// File: rtl/gate_sweeper.sv
// Exhaustive stimulus sweeper for a combinational gate under test.
// Drives every input vector in binary or Gray order and checks the output against a truth table.
module gate_sweeper #(
   parameter int unsigned N_IN = 2,
   parameter int unsigned HOLD = 5
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic                    i_gray_mode,
   input  logic [(1<<N_IN)-1:0]    i_golden_tt,
   input  logic                    i_dut_out,
   output logic [N_IN-1:0]         o_stim,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_pass,
   output logic [N_IN:0]           o_err_count,
   output logic [N_IN-1:0]         o_first_fail_vec,
   output logic                    o_fail_seen
);

   localparam int unsigned NVEC = 1 << N_IN;
   localparam int unsigned HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [N_IN:0]   LAST_IDX  = (N_IN+1)'(NVEC - 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [N_IN:0]     r_idx;
   logic [HC_W-1:0]   r_hold_cnt;
   logic              r_mode;

   logic              w_sample;
   logic              w_mismatch;
   logic [N_IN:0]     w_err_next;
   logic [N_IN:0]     w_idx_next;

   function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i, input logic gray);
      return gray ? (i ^ (i >> 1)) : i;
   endfunction

   always_comb begin
      w_sample   = (r_state == S_HOLD) && (r_hold_cnt == HOLD_LAST);
      w_mismatch = (i_dut_out != i_golden_tt[o_stim]);
      w_err_next = o_err_count + (N_IN+1)'(w_mismatch);
      w_idx_next = r_idx + (N_IN+1)'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= S_IDLE;
         r_idx            <= '0;
         r_hold_cnt       <= '0;
         r_mode           <= 1'b0;
         o_stim           <= '0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_pass           <= 1'b0;
         o_err_count      <= '0;
         o_first_fail_vec <= '0;
         o_fail_seen      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_idx            <= '0;
                  r_hold_cnt       <= '0;
                  r_mode           <= i_gray_mode;
                  o_err_count      <= '0;
                  o_fail_seen      <= 1'b0;
                  o_first_fail_vec <= '0;
                  o_pass           <= 1'b0;
                  o_stim           <= map_vec('0, i_gray_mode);
                  o_busy           <= 1'b1;
                  r_state          <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_sample) begin
                  if (w_mismatch) begin
                     o_err_count <= w_err_next;
                     if (!o_fail_seen) begin
                        o_first_fail_vec <= o_stim;
                        o_fail_seen      <= 1'b1;
                     end
                  end
                  // done/pass are loaded on entry to DONE so they are visible during the DONE cycle
                  if (r_idx == LAST_IDX) begin
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                     o_pass  <= (w_err_next == '0);
                     r_state <= S_DONE;
                  end else begin
                     r_idx      <= w_idx_next;
                     o_stim     <= map_vec(w_idx_next[N_IN-1:0], r_mode);
                     r_hold_cnt <= '0;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt + HC_W'(1);
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweeper.sv
// Directed bench for gate_sweeper: a 2-input/HOLD=5 instance and a 3-input/HOLD=1 instance.
module tb_gate_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // 2-input sweeper, HOLD = 5
   logic       a_start = 1'b0, a_gray = 1'b0, a_fn = 1'b0;
   logic [3:0] a_tt = '0;
   logic       a_dut_out;
   logic [1:0] a_stim, a_ffv;
   logic [2:0] a_err;
   logic       a_busy, a_done, a_pass, a_fs;

   // a_fn: 0 = AND gate, 1 = OR gate
   assign a_dut_out = a_fn ? (a_stim[0] | a_stim[1]) : (a_stim[0] & a_stim[1]);

   gate_sweeper #(.N_IN(2), .HOLD(5)) u_a (
      .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_gray_mode(a_gray),
      .i_golden_tt(a_tt), .i_dut_out(a_dut_out), .o_stim(a_stim), .o_busy(a_busy),
      .o_done(a_done), .o_pass(a_pass), .o_err_count(a_err),
      .o_first_fail_vec(a_ffv), .o_fail_seen(a_fs)
   );

   // 3-input sweeper, HOLD = 1, DUT = majority
   logic       b_start = 1'b0, b_gray = 1'b0;
   logic [7:0] b_tt = 8'b1110_1000;
   logic       b_dut_out;
   logic [2:0] b_stim, b_ffv;
   logic [3:0] b_err;
   logic       b_busy, b_done, b_pass, b_fs;

   assign b_dut_out = (b_stim[0] & b_stim[1]) | (b_stim[0] & b_stim[2]) | (b_stim[1] & b_stim[2]);

   gate_sweeper #(.N_IN(3), .HOLD(1)) u_b (
      .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_gray_mode(b_gray),
      .i_golden_tt(b_tt), .i_dut_out(b_dut_out), .o_stim(b_stim), .o_busy(b_busy),
      .o_done(b_done), .o_pass(b_pass), .o_err_count(b_err),
      .o_first_fail_vec(b_ffv), .o_fail_seen(b_fs)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ord packs the expected visit order: vector k in ord[2k+:2]
   task automatic sweep_a(input string tag, input logic gray, input logic [3:0] tt, input logic fn,
                          input logic [7:0] ord, input logic poke,
                          input int exp_err, input int exp_ffv, input int exp_pass);
      int stim_bad, busy_n, done_n, done_at;
      logic       d_pass, d_fs;
      logic [2:0] d_err;
      logic [1:0] d_ffv;
      stim_bad = 0; busy_n = 0; done_n = 0; done_at = 0;
      d_pass = 1'b0; d_fs = 1'b0; d_err = '0; d_ffv = '0;
      @(negedge clk);
      a_gray = gray; a_tt = tt; a_fn = fn; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      check({tag, "_pass_cleared"}, 32'(a_pass), 0);
      for (int n = 1; n <= 30; n++) begin
         if (n > 1) @(negedge clk);
         if (n <= 20 && a_stim != ord[2*((n-1)/5) +: 2]) stim_bad++;
         if (a_busy) busy_n++;
         if (a_done) begin
            done_n++; done_at = n;
            d_pass = a_pass; d_fs = a_fs; d_err = a_err; d_ffv = a_ffv;
         end
         if (poke && n == 7) begin a_start = 1'b1; a_gray = ~gray; end
         if (poke && n == 9) a_start = 1'b0;
      end
      a_gray = gray;
      check({tag, "_stim_order"}, 32'(stim_bad), 0);
      check({tag, "_busy_cycles"}, 32'(busy_n), 20);
      check({tag, "_done_count"}, 32'(done_n), 1);
      check({tag, "_done_cycle"}, 32'(done_at), 21);
      check({tag, "_err_count"}, 32'(d_err), 32'(exp_err));
      check({tag, "_first_fail"}, 32'(d_ffv), 32'(exp_ffv));
      check({tag, "_fail_seen"}, 32'(d_fs), 32'(exp_err != 0));
      check({tag, "_pass"}, 32'(d_pass), 32'(exp_pass));
      check({tag, "_pass_held"}, 32'(a_pass), 32'(exp_pass));
   endtask

   // ord packs the expected visit order: vector k in ord[3k+:3]
   task automatic sweep_b(input string tag, input logic gray, input logic [23:0] ord);
      int stim_bad, busy_n, done_n, done_at;
      logic d_pass;
      stim_bad = 0; busy_n = 0; done_n = 0; done_at = 0; d_pass = 1'b0;
      @(negedge clk);
      b_gray = gray; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         if (n > 1) @(negedge clk);
         if (n <= 8 && b_stim != ord[3*(n-1) +: 3]) stim_bad++;
         if (b_busy) busy_n++;
         if (b_done) begin done_n++; done_at = n; d_pass = b_pass; end
      end
      check({tag, "_stim_order"}, 32'(stim_bad), 0);
      check({tag, "_busy_cycles"}, 32'(busy_n), 8);
      check({tag, "_done_count"}, 32'(done_n), 1);
      check({tag, "_done_cycle"}, 32'(done_at), 9);
      check({tag, "_pass"}, 32'(d_pass), 1);
      check({tag, "_err_count"}, 32'(b_err), 0);
   endtask

   initial begin
      int done_n;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stim", 32'(a_stim), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_done", 32'(a_done), 0);
      check("rst_pass", 32'(a_pass), 0);
      check("rst_err", 32'(a_err), 0);
      rst = 1'b0;

      // AND gate vs AND table, binary
      sweep_a("and_bin", 1'b0, 4'b1000, 1'b0, 8'b11_10_01_00, 1'b0, 0, 0, 1);
      // OR gate vs XOR table, binary: only 11 differs
      sweep_a("or_xor", 1'b0, 4'b0110, 1'b1, 8'b11_10_01_00, 1'b0, 1, 3, 0);
      // OR gate vs AND table, Gray order 00,01,11,10: 01 and 10 differ
      sweep_a("or_and_gray", 1'b1, 4'b1000, 1'b1, 8'b10_11_01_00, 1'b0, 2, 1, 0);
      // mid-sweep start pulse and gray toggle must be ignored
      sweep_a("poke", 1'b0, 4'b0110, 1'b1, 8'b11_10_01_00, 1'b1, 1, 3, 0);

      // abort a failing sweep (OR vs AND) during vector 2
      @(negedge clk);
      a_gray = 1'b0; a_tt = 4'b1000; a_fn = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_pre_stim", 32'(a_stim), 2);
      check("abort_pre_fail_seen", 32'(a_fs), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_stim", 32'(a_stim), 0);
      check("abort_busy", 32'(a_busy), 0);
      check("abort_done", 32'(a_done), 0);
      check("abort_pass", 32'(a_pass), 0);
      check("abort_err", 32'(a_err), 0);
      check("abort_ffv", 32'(a_ffv), 0);
      check("abort_fail_seen", 32'(a_fs), 0);
      done_n = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (a_done) done_n++;
      end
      check("abort_no_done", 32'(done_n), 0);
      check("abort_idle_busy", 32'(a_busy), 0);
      sweep_a("after_abort", 1'b0, 4'b1000, 1'b0, 8'b11_10_01_00, 1'b0, 0, 0, 1);

      // 3-input majority, HOLD=1
      sweep_b("maj_bin", 1'b0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
      sweep_b("maj_gray", 1'b1, {3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gate_sweeper.md
# gate_sweeper

Parametrised, self-checking stimulus engine for combinational gate blocks with up to N_IN inputs. On `start`, it drives every one of the 2^N_IN input vectors onto the device under test, in binary or Gray order. Each vector is held for HOLD cycles, and the DUT output is then compared against a caller-supplied truth table. The block sits beside the combinational unit under test and reports pass/fail, error count and the first failing vector; this replaces hand-written per-vector stimulus sequences.

## Interface
- N_IN, 2, number of DUT inputs (1..8)
- HOLD, 5, cycles each vector is held before sampling (>=1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- gray_mode  in  1  0 = binary order, 1 = Gray order; captured at start
- golden_tt  in  2^N_IN  expected output; bit k = expected result for stim == k; must be stable while busy
- dut_out  in  1  DUT output (combinational function of stim)
- stim  out  N_IN  registered vector driven to DUT
- busy  out  1  high from first stim cycle through last sample cycle
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  high after a sweep with zero errors; held until next start or reset
- err_count  out  N_IN+1  mismatches in the current/last sweep
- first_fail_vec  out  N_IN  stim value of first mismatch; 0 if none
- fail_seen  out  1  at least one mismatch in the current/last sweep

## Operation
- States: IDLE, HOLD, DONE.
- Registers: idx (N_IN+1 bits), hold_cnt (clog2(HOLD) bits, minimum 1), mode_q.
- IDLE + start: idx<=0, hold_cnt<=0, mode_q<=gray_mode; clear err_count, fail_seen, first_fail_vec, pass; load stim<=map(0); go to HOLD.
- map(i) = i when mode_q=0; i ^ (i>>1) when mode_q=1 (low N_IN bits).
- HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD-1 (sample cycle):
  - compare dut_out with golden_tt[stim], indexed by the vector value, not the step number;
  - on mismatch, err_count++ and, if !fail_seen, first_fail_vec<=stim and fail_seen<=1;
  - if idx==2^N_IN-1, go to DONE; otherwise idx++, stim<=map(idx+1), hold_cnt<=0.
- DONE (one cycle): done=1; pass<=(err_count==0). Then go to IDLE. stim holds its last vector.
- start is ignored in HOLD and DONE and does not queue.
- err_count never overflows, because the maximum value is 2^N_IN.
- reset in any state: IDLE; stim, busy, done, pass, err_count, first_fail_vec, fail_seen, idx, hold_cnt all 0. An aborted sweep produces no done pulse.

## Timing
- start high in cycle t → stim=map(0) and busy=1 from cycle t+1.
- Vector k is driven in cycles t+1+k·HOLD … t+k·HOLD+HOLD. Sampling happens on the clock edge ending its last cycle.
- busy is high for exactly 2^N_IN·HOLD cycles.
- done pulses in cycle t+1+2^N_IN·HOLD; pass and err_count are valid in the same cycle.
- The earliest next start is accepted in the cycle after done, i.e. the cycle IDLE is re-entered.
- HOLD=1: the vector changes every cycle, with a sample every cycle.
- The DUT is combinational, so dut_out for vector k must settle within HOLD cycles. The sweeper adds no extra sampling delay.

## Test plan
- N_IN=2, HOLD=5, golden_tt=4'b1000, DUT=AND, start at t → stim 00,01,10,11 for 5 cycles each; done at t+21; pass=1, err_count=0, fail_seen=0.
- N_IN=2, golden_tt=4'b0110 (XOR), DUT=OR, binary → err_count=1, first_fail_vec=2'b11, pass=0, fail_seen=1.
- Same as above with golden_tt=4'b1000 (AND), DUT=OR, gray_mode=1 → stim order 00,01,11,10; err_count=2; first_fail_vec=2'b01.
- N_IN=3, HOLD=1, golden = 3-input majority, DUT correct → stim changes every cycle; busy 8 cycles; done at t+9; pass=1.
- start pulsed again mid-sweep, and gray_mode toggled mid-sweep → ignored; order and timing unchanged; exactly one done.
- reset asserted at vector 2 of a failing sweep → next cycle all outputs 0, state IDLE, no done. A fresh start then completes normally with counts cleared.
